// File: rtl/rr_replay_unpacker.sv
// rtl/rr_replay_unpacker.sv - replay unit decoder: splits packed logging units into per-channel logb data and loge events
// Optional length check: define RR_UNPACK_LEN_CHECK_EN to compare in_len against the bitmap-derived length.
package rr_replay_unpacker_pkg;
    function automatic int rr_ch_width(input logic [1023:0] widths, input int bits, input int idx);
        int raw;
        raw = int'(32'(widths >> (idx * bits)));
        return (bits >= 32) ? raw : (raw & ((1 << bits) - 1));
    endfunction

    function automatic int rr_sum_widths(input logic [1023:0] widths, input int bits, input int cnt);
        int s;
        s = 0;
        for (int i = 0; i < cnt; i++) s += rr_ch_width(widths, bits, i);
        return s;
    endfunction

    function automatic int rr_max_width(input logic [1023:0] widths, input int bits, input int cnt);
        int m;
        m = 1;
        for (int i = 0; i < cnt; i++)
            if (rr_ch_width(widths, bits, i) > m) m = rr_ch_width(widths, bits, i);
        return m;
    endfunction
endpackage

module rr_replay_unpacker
    import rr_replay_unpacker_pkg::*;
#(
    parameter int RR_CHANNEL_WIDTH_BITS = 16,
    parameter int LOGB_CHANNEL_CNT      = 4,
    parameter int LOGE_CHANNEL_CNT      = 4,
    parameter logic [LOGB_CHANNEL_CNT*RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS =
        {16'd8, 16'd128, 16'd32, 16'd64},
    localparam int HDR_WIDTH    = LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
    localparam int FULL_WIDTH   = rr_sum_widths(1024'(CHANNEL_WIDTHS), RR_CHANNEL_WIDTH_BITS,
                                                LOGB_CHANNEL_CNT) + HDR_WIDTH,
    localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
    localparam int MAX_CH_WIDTH = rr_max_width(1024'(CHANNEL_WIDTHS), RR_CHANNEL_WIDTH_BITS,
                                               LOGB_CHANNEL_CNT)
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [FULL_WIDTH-1:0]                    in_data,
    input  logic [OFFSET_WIDTH-1:0]                  in_len,
    output logic [LOGB_CHANNEL_CNT-1:0]              logb_valid,
    input  logic [LOGB_CHANNEL_CNT-1:0]              logb_ready,
    output logic [LOGB_CHANNEL_CNT*MAX_CH_WIDTH-1:0] logb_data,
    output logic [LOGE_CHANNEL_CNT-1:0]              loge_valid,
    input  logic [LOGE_CHANNEL_CNT-1:0]              loge_ready,
    output logic [31:0]                              unit_cnt,
    output logic                                     len_err
);
    localparam logic [1023:0] CW_VEC = 1024'(CHANNEL_WIDTHS);

    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state;

    logic [LOGB_CHANNEL_CNT-1:0] in_b;
    logic [LOGE_CHANNEL_CNT-1:0] in_e;
    logic                        hs;
    logic [OFFSET_WIDTH-1:0]     comp_len;
    logic [MAX_CH_WIDTH-1:0]     payload [LOGB_CHANNEL_CNT];
    logic [LOGB_CHANNEL_CNT-1:0] next_b;
    logic [LOGE_CHANNEL_CNT-1:0] next_e;

    assign in_b   = in_data[LOGB_CHANNEL_CNT-1:0];
    assign in_e   = in_data[HDR_WIDTH-1:LOGB_CHANNEL_CNT];
    assign hs     = in_valid & in_ready;
    assign next_b = logb_valid & ~logb_ready;
    assign next_e = loge_valid & ~loge_ready;

    // Running prefix sum of present channels: each step adds a constant width, so no multiplier.
    always_comb begin
        logic [OFFSET_WIDTH-1:0] acc;
        logic [FULL_WIDTH-1:0]   sh;
        acc = OFFSET_WIDTH'(HDR_WIDTH);
        for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
            sh         = in_data >> acc;
            payload[i] = '0;
            for (int b = 0; b < MAX_CH_WIDTH; b++)
                if (b < rr_ch_width(CW_VEC, RR_CHANNEL_WIDTH_BITS, i)) payload[i][b] = sh[b];
            if (in_b[i]) acc = acc + OFFSET_WIDTH'(rr_ch_width(CW_VEC, RR_CHANNEL_WIDTH_BITS, i));
        end
        comp_len = acc;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            logb_valid <= '0;
            loge_valid <= '0;
            logb_data  <= '0;
            unit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < LOGB_CHANNEL_CNT; i++)
                            if (in_b[i]) logb_data[i*MAX_CH_WIDTH +: MAX_CH_WIDTH] <= payload[i];
                        if (in_b == '0 && in_e == '0) begin
                            unit_cnt <= unit_cnt + 32'd1;
                        end else begin
                            logb_valid <= in_b;
                            loge_valid <= in_e;
                            in_ready   <= 1'b0;
                            state      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    logb_valid <= next_b;
                    loge_valid <= next_e;
                    // Unit retires only once the last addressed channel has taken it.
                    if (next_b == '0 && next_e == '0) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        unit_cnt <= unit_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RR_UNPACK_LEN_CHECK_EN
    logic len_err_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) len_err_q <= 1'b0;
        else if (hs && in_len != comp_len) len_err_q <= 1'b1;
    end
    assign len_err = len_err_q;
`ifndef SYNTHESIS
    always @(posedge clk)
        if (rstn && hs && in_len != comp_len)
            $display("rr_replay_unpacker: length mismatch in_len=%0d computed=%0d logb=%b loge=%b",
                     in_len, comp_len, in_b, in_e);
`endif
`else
    logic unused_len;
    assign unused_len = ^{in_len, comp_len, hs};
    assign len_err    = 1'b0;
`endif
endmodule

// File: tb/tb_rr_replay_unpacker.sv
// tb/tb_rr_replay_unpacker.sv - randomized self-checking bench for rr_replay_unpacker
module tb_rr_replay_unpacker;
    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid;
    logic         in_ready;
    logic [239:0] in_data;
    logic [7:0]   in_len;
    logic [3:0]   logb_valid;
    logic [3:0]   logb_ready;
    logic [511:0] logb_data;
    logic [3:0]   loge_valid;
    logic [3:0]   loge_ready;
    logic [31:0]  unit_cnt;
    logic         len_err;

`ifdef RR_UNPACK_LEN_CHECK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int ucnt  = 0;
    int width_tab [4] = '{64, 32, 128, 8};
    logic [127:0] exp_pl [4];

    rr_replay_unpacker dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_len(in_len), .logb_valid(logb_valid),
        .logb_ready(logb_ready), .logb_data(logb_data), .loge_valid(loge_valid),
        .loge_ready(loge_ready), .unit_cnt(unit_cnt), .len_err(len_err)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] mask_w(input int w);
        return (w >= 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
    endfunction

    task automatic rand_payloads();
        for (int i = 0; i < 4; i++)
            exp_pl[i] = {$urandom, $urandom, $urandom, $urandom} & mask_w(width_tab[i]);
    endtask

    // Reference packer: append present payloads after the header, LSB first.
    task automatic pack(input logic [3:0] b, input logic [3:0] e);
        int pos;
        logic [239:0] d;
        d = '0;
        d[3:0] = b;
        d[7:4] = e;
        pos = 8;
        for (int i = 0; i < 4; i++)
            if (b[i]) begin
                d = d | (240'(exp_pl[i]) << pos);
                pos += width_tab[i];
            end
        in_data = d;
        in_len  = 8'(pos);
    endtask

    task automatic send();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            total++; bad++;
            $display("FAIL send_timeout in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({in_ready, logb_valid, loge_valid, len_err} !== {1'b1, 4'b0, 4'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_flags got rdy=%b bv=%b ev=%b le=%b", in_ready, logb_valid, loge_valid, len_err);
        end
        total++;
        if (logb_data !== '0 || unit_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got cnt=%0d data_nonzero=%b required cnt=0", unit_cnt, |logb_data);
        end
    endtask

    task automatic test_basic();
        logb_ready = 4'hF; loge_ready = 4'hF;
        rand_payloads();
        exp_pl[0] = 128'hA5A5_A5A5_A5A5_A5A5;
        exp_pl[2] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        pack(4'b0101, 4'b0000);
        total++;
        if (in_len !== 8'd200) begin
            bad++; $display("FAIL basic_len got %0d required 200", in_len);
        end
        send();
        total++;
        if (logb_valid !== 4'b0101 || in_ready !== 1'b0) begin
            bad++; $display("FAIL basic_valid got bv=%b rdy=%b required 0101/0", logb_valid, in_ready);
        end
        total++;
        if (logb_data[0 +: 128] !== exp_pl[0] || logb_data[256 +: 128] !== exp_pl[2]) begin
            bad++;
            $display("FAIL basic_data got ch0=%h ch2=%h required ch0=%h ch2=%h",
                     logb_data[0 +: 128], logb_data[256 +: 128], exp_pl[0], exp_pl[2]);
        end
        @(posedge clk); #1;
        ucnt++;
        total++;
        if ({logb_valid, in_ready, len_err} !== {4'b0, 1'b1, 1'b0} || unit_cnt !== 32'(ucnt)) begin
            bad++;
            $display("FAIL basic_done got bv=%b rdy=%b le=%b cnt=%0d required 0000/1/0/%0d",
                     logb_valid, in_ready, len_err, unit_cnt, ucnt);
        end
    endtask

    task automatic test_stall();
        logic [127:0] ch2;
        logb_ready = 4'b1011; loge_ready = 4'hF;
        rand_payloads();
        pack(4'b0101, 4'b0000);
        send();
        ch2 = exp_pl[2];
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            total++;
            if (logb_valid !== 4'b0100 || in_ready !== 1'b0 || unit_cnt !== 32'(ucnt) ||
                logb_data[256 +: 128] !== ch2) begin
                bad++;
                $display("FAIL stall_hold cyc=%0d got bv=%b rdy=%b cnt=%0d ch2=%h required 0100/0/%0d/%h",
                         c, logb_valid, in_ready, unit_cnt, logb_data[256 +: 128], ucnt, ch2);
            end
        end
        logb_ready = 4'hF;
        @(posedge clk); #1;
        ucnt++;
        total++;
        if (logb_valid !== 4'b0 || in_ready !== 1'b1 || unit_cnt !== 32'(ucnt)) begin
            bad++;
            $display("FAIL stall_release got bv=%b rdy=%b cnt=%0d required 0000/1/%0d",
                     logb_valid, in_ready, unit_cnt, ucnt);
        end
    endtask

    task automatic test_loge_only();
        logb_ready = 4'hF; loge_ready = 4'hF;
        rand_payloads();
        pack(4'b0000, 4'b1000);
        send();
        total++;
        if (loge_valid !== 4'b1000 || logb_valid !== 4'b0) begin
            bad++; $display("FAIL loge_valid got ev=%b bv=%b required 1000/0000", loge_valid, logb_valid);
        end
        @(posedge clk); #1;
        ucnt++;
        total++;
        if (loge_valid !== 4'b0 || unit_cnt !== 32'(ucnt)) begin
            bad++; $display("FAIL loge_done got ev=%b cnt=%0d required 0000/%0d", loge_valid, unit_cnt, ucnt);
        end
    endtask

    task automatic test_empty();
        pack(4'b0000, 4'b0000);
        send();
        ucnt++;
        total++;
        if (in_ready !== 1'b1 || logb_valid !== 4'b0 || loge_valid !== 4'b0 || unit_cnt !== 32'(ucnt)) begin
            bad++;
            $display("FAIL empty_unit got rdy=%b bv=%b ev=%b cnt=%0d required 1/0000/0000/%0d",
                     in_ready, logb_valid, loge_valid, unit_cnt, ucnt);
        end
    endtask

    task automatic test_random();
        logic [3:0] pb, pe;
        int cyc;
        for (int u = 0; u < 40; u++) begin
            pb = 4'($urandom); pe = 4'($urandom);
            rand_payloads();
            pack(pb, pe);
            logb_ready = 4'($urandom); loge_ready = 4'($urandom);
            send();
            cyc = 0;
            while ((pb | pe) != 4'b0 && cyc < 100) begin
                total++;
                if ({logb_valid, loge_valid, in_ready} !== {pb, pe, 1'b0}) begin
                    bad++;
                    $display("FAIL rand_valid unit=%0d got bv=%b ev=%b rdy=%b required %b/%b/0",
                             u, logb_valid, loge_valid, in_ready, pb, pe);
                end
                for (int i = 0; i < 4; i++)
                    if (pb[i]) begin
                        total++;
                        if (logb_data[i*128 +: 128] !== exp_pl[i]) begin
                            bad++;
                            $display("FAIL rand_data unit=%0d ch=%0d got %h required %h",
                                     u, i, logb_data[i*128 +: 128], exp_pl[i]);
                        end
                    end
                logb_ready = 4'($urandom); loge_ready = 4'($urandom);
                @(posedge clk); #1;
                pb = pb & ~logb_ready;
                pe = pe & ~loge_ready;
                cyc++;
            end
            if (cyc >= 100) begin
                total++; bad++;
                $display("FAIL rand_drain_timeout unit=%0d", u);
            end
            ucnt++;
            total++;
            if (unit_cnt !== 32'(ucnt) || in_ready !== 1'b1 || logb_valid !== 4'b0 || loge_valid !== 4'b0) begin
                bad++;
                $display("FAIL rand_done unit=%0d got cnt=%0d rdy=%b bv=%b ev=%b required %0d/1/0000/0000",
                         u, unit_cnt, in_ready, logb_valid, loge_valid, ucnt);
            end
        end
    endtask

    task automatic test_len_err();
        logb_ready = 4'hF; loge_ready = 4'hF;
        rand_payloads();
        pack(4'b1111, 4'b0000);
        total++;
        if (in_len !== 8'd240) begin
            bad++; $display("FAIL len_full got %0d required 240", in_len);
        end
        in_len = 8'd199;
        send();
        total++;
        if (len_err !== LEN_CHK || logb_valid !== 4'b1111) begin
            bad++; $display("FAIL len_err_set got le=%b bv=%b required %b/1111", len_err, logb_valid, LEN_CHK);
        end
        @(posedge clk); #1;
        ucnt++;
        rand_payloads();
        pack(4'b0001, 4'b0000);
        send();
        @(posedge clk); #1;
        ucnt++;
        total++;
        if (len_err !== LEN_CHK || unit_cnt !== 32'(ucnt)) begin
            bad++; $display("FAIL len_err_sticky got le=%b cnt=%0d required %b/%0d", len_err, unit_cnt, LEN_CHK, ucnt);
        end
    endtask

    task automatic test_reset_mid_drain();
        logb_ready = 4'b0; loge_ready = 4'b0;
        rand_payloads();
        pack(4'b0010, 4'b0000);
        send();
        total++;
        if (logb_valid !== 4'b0010) begin
            bad++; $display("FAIL rst_pre got bv=%b required 0010", logb_valid);
        end
        #2 rstn = 1'b0;
        #1;
        ucnt = 0;
        total++;
        if (logb_valid !== 4'b0 || loge_valid !== 4'b0 || logb_data !== '0 || unit_cnt !== 32'd0 || len_err !== 1'b0) begin
            bad++;
            $display("FAIL rst_async got bv=%b ev=%b cnt=%0d le=%b required all zero",
                     logb_valid, loge_valid, unit_cnt, len_err);
        end
        @(negedge clk); rstn = 1'b1;
        logb_ready = 4'hF; loge_ready = 4'hF;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || logb_valid !== 4'b0 || unit_cnt !== 32'd0) begin
            bad++; $display("FAIL rst_release got rdy=%b bv=%b cnt=%0d required 1/0000/0", in_ready, logb_valid, unit_cnt);
        end
    endtask

    initial begin
        rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0;
        logb_ready = '0; loge_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_stall();
        test_loge_only();
        test_empty();
        test_random();
        test_len_err();
        test_reset_mid_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
